// File: rtl/fm_streamer_pkg.sv
// Shared types and sizing helpers for the feature-map streamer.
package fm_streamer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } fm_state_t;

   function automatic int padded_side(input int fm_size, input int padding);
      return fm_size + 2 * padding;
   endfunction

   // One extra code point so the far pad boundary (PADDING+FM_SIZE) always fits.
   function automatic int coord_width(input int fm_size, input int padding);
      return $clog2(padded_side(fm_size, padding) + 1);
   endfunction

endpackage

// File: rtl/fm_streamer_if.sv
// Streamer-facing bundle: start/busy/done control, feature-map memory read port, PE pixel stream.
`include "global.v"

interface fm_streamer_if #(
   parameter int ADDR_WIDTH = 5
);
   logic                           i_start;
   logic                           o_busy;
   logic                           o_done;
   logic                           o_rd_en;
   logic [ADDR_WIDTH-1:0]          o_rd_addr;
   logic signed [`A_DSP_WIDTH-1:0] i_rd_data;
   logic signed [`A_DSP_WIDTH-1:0] o_DataFM;
   logic                           o_en;

   modport master (
      input  i_start, i_rd_data,
      output o_busy, o_done, o_rd_en, o_rd_addr, o_DataFM, o_en
   );

   modport slave (
      output i_start, i_rd_data,
      input  o_busy, o_done, o_rd_en, o_rd_addr, o_DataFM, o_en
   );
endinterface

// File: rtl/fm_streamer_raster.sv
// Padded raster counter: walks (row, col) over the P x P padded frame and flags border pixels.
module fm_raster_counter
   import fm_streamer_pkg::*;
#(
   parameter  int FM_SIZE = 5,
   parameter  int PADDING = 0,
   localparam int CW      = coord_width(FM_SIZE, PADDING)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_step,
   output logic [CW-1:0] row,
   output logic [CW-1:0] col,
   output logic          is_pad,
   output logic          last
);

   localparam int            P     = padded_side(FM_SIZE, PADDING);
   localparam logic [CW-1:0] LAST  = CW'(P - 1);

   // Column is the inner loop; the counter wraps to (0,0) after the final pixel.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         row <= '0;
         col <= '0;
      end else if (i_step) begin
         if (col == LAST) begin
            col <= '0;
            row <= (row == LAST) ? '0 : row + 1'b1;
         end else begin
            col <= col + 1'b1;
         end
      end
   end

   assign last = (row == LAST) && (col == LAST);

   generate
      if (PADDING == 0) begin : g_no_pad
         assign is_pad = 1'b0;
      end else begin : g_pad
         localparam logic [CW-1:0] LO = CW'(PADDING);
         localparam logic [CW-1:0] HI = CW'(PADDING + FM_SIZE);
         assign is_pad = (row < LO) || (row >= HI) || (col < LO) || (col >= HI);
      end
   endgenerate

endmodule

// File: rtl/global.v
// Shared DSP datapath width constants used by every block that talks to the PE array.
`ifndef GLOBAL_V
`define GLOBAL_V
`define A_DSP_WIDTH 30
`define B_DSP_WIDTH 18
`define C_DSP_WIDTH 48
`define P_DSP_WIDTH 48
`endif

// File: rtl/fm_streamer.sv
// Streams a zero-padded feature map from memory to the PE in raster order, one pixel per cycle.
module fm_streamer
   import fm_streamer_pkg::*;
#(
   parameter int FM_SIZE    = 5,
   parameter int PADDING    = 0,
   parameter int ADDR_WIDTH = $clog2(FM_SIZE * FM_SIZE)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   fm_streamer_if.master bus
);

   localparam int            CW      = coord_width(FM_SIZE, PADDING);
   localparam logic [CW-1:0] PAD_OFS = CW'(PADDING);

   fm_state_t     state_q, state_d;
   logic          issue, issue_rd;
   logic          is_pad, last;
   logic [CW-1:0] row, col, row_i, col_i;
   logic          valid_s1, pad_s1;

   fm_raster_counter #(
      .FM_SIZE (FM_SIZE),
      .PADDING (PADDING)
   ) u_raster (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_step (issue),
      .row    (row),
      .col    (col),
      .is_pad (is_pad),
      .last   (last)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // DRAIN waits until the last issued pixel has left the first pipeline stage.
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         ST_IDLE:   if (bus.i_start) state_d = ST_STREAM;
         ST_STREAM: begin
            issue = 1'b1;
            if (last) state_d = ST_DRAIN;
         end
         ST_DRAIN:  if (!valid_s1) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   assign issue_rd      = issue && !is_pad;
   assign row_i         = row - PAD_OFS;
   assign col_i         = col - PAD_OFS;
   assign bus.o_rd_en   = issue_rd;
   assign bus.o_rd_addr = issue_rd ? (ADDR_WIDTH'(row_i) * ADDR_WIDTH'(FM_SIZE) + ADDR_WIDTH'(col_i))
                                   : '0;
   assign bus.o_busy    = (state_q != ST_IDLE);
   assign bus.o_done    = (state_q == ST_DONE);

   // Stage 1 waits for the memory's one-cycle latency; stage 2 registers the PE-facing pixel.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_s1     <= 1'b0;
         pad_s1       <= 1'b0;
         bus.o_en     <= 1'b0;
         bus.o_DataFM <= '0;
      end else begin
         valid_s1     <= issue;
         pad_s1       <= is_pad;
         bus.o_en     <= valid_s1;
         bus.o_DataFM <= (valid_s1 && !pad_s1) ? bus.i_rd_data : '0;
      end
   end

endmodule

// File: doc/fm_streamer.md
FM_STREAMER -- requirements
Module: fm_streamer

Interface
REQ-001 Parameter FM_SIZE, default 5, unpadded feature-map side length in pixels.
REQ-002 Parameter PADDING, default 0, zero-pixel border width inserted on every side.
REQ-003 Parameter ADDR_WIDTH, default $clog2(FM_SIZE*FM_SIZE), feature-map memory address width.
REQ-004 i_clk  input  1  single clock; all logic on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_start  input  1  start request; frame begins when sampled high in IDLE.
REQ-007 o_busy  output  1  high from the start-accepting edge until o_done pulses.
REQ-008 o_done  output  1  one-cycle pulse at end of frame.
REQ-009 o_rd_en  output  1  feature-map memory read strobe.
REQ-010 o_rd_addr  output  ADDR_WIDTH  memory address, row-major: row*FM_SIZE+col.
REQ-011 i_rd_data  input  `A_DSP_WIDTH  signed memory data, valid exactly one cycle after o_rd_en.
REQ-012 o_DataFM  output  `A_DSP_WIDTH  signed pixel stream to the PE data input.
REQ-013 o_en  output  1  pixel-valid, driven to the PE enable input.

Function
REQ-014 State machine: IDLE -> STREAM on i_start; STREAM -> DRAIN after the last padded pixel is issued; DRAIN -> DONE after the last pixel is output; DONE -> IDLE after one cycle.
REQ-015 Padded side P = FM_SIZE + 2*PADDING; one frame outputs exactly P*P pixels in raster order (row outer, column inner).
REQ-016 Padded coordinate (r,c) is a pad pixel when r or c < PADDING or >= PADDING+FM_SIZE; pad pixels output 0 and never assert o_rd_en.
REQ-017 Interior pixels assert o_rd_en for one cycle with o_rd_addr = (r-PADDING)*FM_SIZE + (c-PADDING); exactly FM_SIZE*FM_SIZE reads per frame.
REQ-018 Issue stage advances one padded pixel per cycle in STREAM; no bubbles.
REQ-019 Output stage is registered: a pixel issued in cycle n appears on o_DataFM with o_en high in cycle n+2; first o_en high 2 cycles after the i_start-sampling edge.
REQ-020 o_en held continuously high for exactly P*P consecutive cycles per frame, then low; no gaps (the PE counter restarts when o_en drops).
REQ-021 o_DataFM passes i_rd_data bit-exact (sign preserved); o_DataFM = 0 whenever o_en is low.
REQ-022 o_done pulses in the cycle after the last o_en-high cycle; o_busy falls in the same cycle o_done falls.
REQ-023 i_start while o_busy is high is ignored; i_start held high in DONE/IDLE starts a new frame on the next IDLE edge.
REQ-024 PADDING = 0 yields a stream with no pad pixels; FM_SIZE = 1 yields a single read and, for PADDING = 0, a one-cycle o_en.

Reset
REQ-025 Asserting i_rst at any time, including mid-frame, immediately forces IDLE and drives o_busy, o_done, o_rd_en, o_en low and o_rd_addr, o_DataFM to 0.
REQ-026 After i_rst deasserts, no output activity occurs until a new i_start is sampled; no partial frame resumes.

Structure
REQ-027 `A_DSP_WIDTH and the other DSP width constants come from the shared global.v include; no local redefinition.
REQ-028 The padded row/column counter with pad-region flags is one sub-module, fm_raster_counter (parameters FM_SIZE, PADDING; outputs row, col, is_pad, last).
REQ-029 The FSM, read-address generation and the two-stage output alignment pipeline reside in fm_streamer.

Verification
REQ-030 FM_SIZE=5, PADDING=0, mem[a]=a+1, pulse i_start -> o_en high 25 consecutive cycles, o_DataFM = 1..25 in order, 25 reads, o_done one cycle after the last pixel.
REQ-031 FM_SIZE=5, PADDING=1, same memory -> 49 o_en cycles; first 8 outputs 0, 9th = 1; last 8 outputs 0; exactly 25 reads.
REQ-032 mem[0] = -3, FM_SIZE=5, PADDING=0 -> first o_DataFM equals -3 sign-extended to `A_DSP_WIDTH.
REQ-033 i_start re-pulsed at output pixel 10 -> ignored; frame still 25 pixels, one o_done.
REQ-034 i_rst asserted at output pixel 10 -> all outputs 0 asynchronously; after release, a new i_start yields a full clean 25-pixel frame starting at value 1.
REQ-035 i_start held high continuously -> back-to-back frames, each of 25 contiguous o_en cycles, separated by o_en low through DONE/IDLE.
